fifo_stream_reader: RTL and testbench

Read-side drain engine for the team's synchronous FIFO. Issues FIFO read strobes, absorbs the FIFO's fixed 1-cycle read latency, and presents the data as a valid/ready stream with full throughput and no bubbles. Sits between the FIFO read port and any downstream consumer that applies backpressure.

---
 rtl/fifo_stream_reader.sv | 130 +++++++++++++
 tb/tb_fifo_stream_reader.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side drain engine: issues FIFO reads, absorbs the 1-cycle read latency and
// presents a bubble-free valid/ready stream. Optional TLAST generation under FIFO_READER_TLAST_EN.
module fifo_stream_reader #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_LVL_W      = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  output logic                    o_fifo_rden,
  input  logic [P_DATA_WIDTH-1:0] i_fifo_rdata,
  input  logic                    i_fifo_rddata_valid,
  input  logic [P_LVL_W-1:0]      i_fifo_level,
  input  logic                    i_flush,
  output logic                    o_tvalid,
  output logic [P_DATA_WIDTH-1:0] o_tdata,
  input  logic                    i_tready,
`ifdef FIFO_READER_TLAST_EN
  input  logic [15:0]             i_cfg_pkt_len,
  output logic                    o_tlast,
`endif
  output logic [1:0]              o_buf_cnt,
  output logic [7:0]              o_drop_cnt
);

  logic [1:0]              occ, occ_nxt;
  logic [P_DATA_WIDTH-1:0] head, head_nxt;
  logic [P_DATA_WIDTH-1:0] skid, skid_nxt;
  logic                    inflight;
  logic                    flush_d;
  logic [7:0]              drop_cnt, drop_nxt;
  logic [2:0]              drop_add;
  logic [8:0]              drop_sum;
  logic [2:0]              room;
  logic                    pop;
  logic                    take;

  assign pop      = o_tvalid & i_tready;
  assign o_tvalid = (occ != 2'd0);
  assign o_tdata  = head;
  assign o_buf_cnt  = occ;
  assign o_drop_cnt = drop_cnt;

  // Words that will still be held after this edge if a read were not issued now.
  assign room = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign o_fifo_rden = i_rst_n & (i_fifo_level != '0) & ~i_flush & (room < 3'd2);

  // Data returning in the flush cycle or the one after belongs to the discarded stream.
  assign take = i_fifo_rddata_valid & ~i_flush & ~flush_d;

  always_comb begin
    occ_nxt  = occ;
    head_nxt = head;
    skid_nxt = skid;
    if (i_flush) begin
      occ_nxt = 2'd0;
    end else begin
      case ({pop, take})
        2'b11: begin
          if (occ == 2'd2) begin
            head_nxt = skid;
            skid_nxt = i_fifo_rdata;
          end else begin
            head_nxt = i_fifo_rdata;
          end
        end
        2'b10: begin
          if (occ == 2'd2) head_nxt = skid;
          occ_nxt = occ - 2'd1;
        end
        2'b01: begin
          if (occ == 2'd0) begin
            head_nxt = i_fifo_rdata;
            occ_nxt  = 2'd1;
          end else begin
            skid_nxt = i_fifo_rdata;
            occ_nxt  = 2'd2;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    drop_add = 3'd0;
    if (i_flush)
      drop_add = {1'b0, occ} - {2'b00, pop} + {2'b00, i_fifo_rddata_valid};
    else if (flush_d & i_fifo_rddata_valid)
      drop_add = 3'd1;
    drop_sum = {1'b0, drop_cnt} + {6'd0, drop_add};
    drop_nxt = drop_sum[8] ? 8'hff : drop_sum[7:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      occ      <= 2'd0;
      head     <= '0;
      skid     <= '0;
      inflight <= 1'b0;
      flush_d  <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      occ      <= occ_nxt;
      head     <= head_nxt;
      skid     <= skid_nxt;
      inflight <= o_fifo_rden;
      flush_d  <= i_flush;
      drop_cnt <= drop_nxt;
    end
  end

`ifdef FIFO_READER_TLAST_EN
  logic [15:0] beat_cnt;
  logic [15:0] last_idx;

  assign last_idx = (i_cfg_pkt_len == 16'd0) ? 16'd0 : i_cfg_pkt_len - 16'd1;
  // Counter only moves on pop, so tlast is as stable as the head word under backpressure.
  assign o_tlast  = o_tvalid & (beat_cnt == last_idx);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      beat_cnt <= 16'd0;
    else if (i_flush)
      beat_cnt <= 16'd0;
    else if (pop)
      beat_cnt <= o_tlast ? 16'd0 : beat_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: emulated FIFO, queue-based stream model checked
// every cycle, plus literal expectations per scenario.
module tb_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rden;
  logic [7:0] fifo_data;
  logic       fifo_valid;
  logic [4:0] level;
  logic       flush;
  logic       tvalid;
  logic [7:0] tdata;
  logic       tready;
  logic [1:0] buf_cnt;
  logic [7:0] drop_cnt;
`ifdef FIFO_READER_TLAST_EN
  logic [15:0] pkt_len;
  logic        tlast;
`endif

  fifo_stream_reader #(.P_DATA_WIDTH(8), .P_LVL_W(5)) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .o_fifo_rden        (rden),
    .i_fifo_rdata       (fifo_data),
    .i_fifo_rddata_valid(fifo_valid),
    .i_fifo_level       (level),
    .i_flush            (flush),
    .o_tvalid           (tvalid),
    .o_tdata            (tdata),
    .i_tready           (tready),
`ifdef FIFO_READER_TLAST_EN
    .i_cfg_pkt_len      (pkt_len),
    .o_tlast            (tlast),
`endif
    .o_buf_cnt          (buf_cnt),
    .o_drop_cnt         (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Emulated FIFO: registered level, read data one cycle after the strobe.
  logic [7:0] fifo_q[$];
  logic       rd_s;
  initial begin
    fifo_data  = 8'h00;
    fifo_valid = 1'b0;
    level      = 5'd0;
  end
  always begin
    @(negedge clk);
    rd_s = rden;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      fifo_valid = 1'b0;
    end else if (rd_s && fifo_q.size() > 0) begin
      fifo_data  = fifo_q.pop_front();
      fifo_valid = 1'b1;
    end else begin
      fifo_valid = 1'b0;
    end
    level = 5'(fifo_q.size());
  end

  // Model: undelivered words in read order; the newest one is in flight if read last cycle.
  logic [7:0] exp_q[$];
  int infl_m = 0;
  int drop_m = 0;
  int beat_m = 0;
  always @(negedge clk) begin
    int sz, bm, pop;
    if (!rst_n) begin
      exp_q.delete();
      infl_m = 0;
      drop_m = 0;
      beat_m = 0;
    end else begin
      sz  = exp_q.size();
      bm  = sz - infl_m;
      pop = (tvalid && tready) ? 1 : 0;
      check("m_tvalid", 32'(tvalid), 32'(bm != 0));
      check("m_buf_cnt", 32'(buf_cnt), 32'(bm));
      if (tvalid && sz > 0) check("m_tdata", 32'(tdata), 32'(exp_q[0]));
      check("m_drop_cnt", 32'(drop_cnt), 32'(drop_m));
      check("m_rden", 32'(rden), 32'((level != 0) && !flush && (sz - pop) < 2));
      check("m_no_overflow", 32'(fifo_valid && buf_cnt == 2'd2 && pop == 0), 32'(0));
`ifdef FIFO_READER_TLAST_EN
      if (tvalid)
        check("m_tlast", 32'(tlast), 32'(beat_m == ((pkt_len == 0) ? 0 : int'(pkt_len) - 1)));
`endif
      if (flush) begin
        drop_m = (drop_m + sz - pop > 255) ? 255 : drop_m + sz - pop;
        exp_q.delete();
        infl_m = 0;
        beat_m = 0;
      end else begin
        if (pop == 1) begin
          void'(exp_q.pop_front());
`ifdef FIFO_READER_TLAST_EN
          beat_m = (beat_m == ((pkt_len == 0) ? 0 : int'(pkt_len) - 1)) ? 0 : beat_m + 1;
`endif
        end
        infl_m = 0;
        if (rden && fifo_q.size() > 0) begin
          exp_q.push_back(fifo_q[0]);
          infl_m = 1;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic drive_edge();
    @(posedge clk);
    #2;
  endtask

  int rden_n, first_v, last_v;
  logic [7:0] got[$];
  logic [15:0] tl_beats[$];
  bit found;

  initial begin
    rst_n  = 1'b0;
    tready = 1'b0;
    flush  = 1'b0;
`ifdef FIFO_READER_TLAST_EN
    pkt_len = 16'd4;
`endif
    for (int i = 1; i <= 16; i++) fifo_q.push_back(8'(i));
    #1;
    check("reset_tvalid", 32'(tvalid), 32'(0));
    check("reset_tdata", 32'(tdata), 32'(0));
    check("reset_buf_cnt", 32'(buf_cnt), 32'(0));
    check("reset_drop_cnt", 32'(drop_cnt), 32'(0));
    check("reset_rden", 32'(rden), 32'(0));
    repeat (2) drive_edge();
    rst_n  = 1'b1;
    tready = 1'b1;

    // Full-throughput drain of 16 preloaded words.
    rden_n = 0; first_v = -1; last_v = -1; got.delete();
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (rden) rden_n++;
      if (tvalid) begin
        if (first_v < 0) first_v = i;
        last_v = i;
        got.push_back(tdata);
      end
    end
    check("t1_rden_cycles", 32'(rden_n), 32'(16));
    check("t1_first_valid", 32'(first_v), 32'(2));
    check("t1_no_bubbles", 32'(last_v - first_v), 32'(15));
    check("t1_beats", 32'(got.size()), 32'(16));
    for (int k = 0; k < 16 && k < got.size(); k++) check("t1_data", 32'(got[k]), 32'(k + 1));

    // Backpressure with 3 words: buffer fills to 2, head stays put.
    drive_edge();
    tready = 1'b0;
    fifo_q.push_back(8'h21); fifo_q.push_back(8'h22); fifo_q.push_back(8'h23);
    rden_n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rden) rden_n++;
    end
    check("t2_rden_pulses", 32'(rden_n), 32'(2));
    check("t2_buf_cnt", 32'(buf_cnt), 32'(2));
    check("t2_tvalid", 32'(tvalid), 32'(1));
    check("t2_tdata", 32'(tdata), 32'(8'h21));
    drive_edge();
    tready = 1'b1;
    got.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (tvalid) got.push_back(tdata);
    end
    check("t2_beats", 32'(got.size()), 32'(3));
    for (int k = 0; k < 3 && k < got.size(); k++) check("t2_data", 32'(got[k]), 32'(8'h21 + k));

    // Alternating ready.
    drive_edge();
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'h31 + i));
    got.delete();
    for (int i = 0; i < 40; i++) begin
      tready = (i % 2 == 0);
      @(negedge clk);
      if (tvalid && tready) got.push_back(tdata);
      drive_edge();
    end
    check("t3_beats", 32'(got.size()), 32'(8));
    for (int k = 0; k < 8 && k < got.size(); k++) check("t3_data", 32'(got[k]), 32'(8'h31 + k));

    // Flush with a full buffer, then with one buffered and one in flight.
    tready = 1'b0;
    for (int i = 0; i < 6; i++) fifo_q.push_back(8'(8'h41 + i));
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (buf_cnt == 2'd2) found = 1;
    end
    check("t4_fill", 32'(found), 32'(1));
    drive_edge();
    flush = 1'b1;
    drive_edge();
    flush = 1'b0;
    @(negedge clk);
    check("t4_tvalid_after_flush", 32'(tvalid), 32'(0));
    check("t4_buf_after_flush", 32'(buf_cnt), 32'(0));
    check("t4_drop_2", 32'(drop_cnt), 32'(2));
    drive_edge();
    drive_edge();
    @(negedge clk);
    check("t4_occ1_infl1_buf", 32'(buf_cnt), 32'(1));
    check("t4_occ1_infl1_valid", 32'(fifo_valid), 32'(1));
    drive_edge();
    flush = 1'b1;
    drive_edge();
    flush = 1'b0;
    @(negedge clk);
    check("t4_drop_4", 32'(drop_cnt), 32'(4));
    check("t4_tvalid_after_flush2", 32'(tvalid), 32'(0));
    drive_edge();
    tready = 1'b1;
    got.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (tvalid) got.push_back(tdata);
    end
    check("t4_beats", 32'(got.size()), 32'(2));
    if (got.size() > 0) check("t4_next_word", 32'(got[0]), 32'(8'h45));

    // Asynchronous reset with a full buffer.
    drive_edge();
    tready = 1'b0;
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'(8'h51 + i));
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (buf_cnt == 2'd2) found = 1;
    end
    check("t5_fill", 32'(found), 32'(1));
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_tvalid", 32'(tvalid), 32'(0));
    check("t5_tdata", 32'(tdata), 32'(0));
    check("t5_buf_cnt", 32'(buf_cnt), 32'(0));
    check("t5_drop_cnt", 32'(drop_cnt), 32'(0));
    check("t5_rden", 32'(rden), 32'(0));
    fifo_q.delete();
    repeat (2) drive_edge();
    rst_n = 1'b1;
    tready = 1'b1;
    fifo_q.push_back(8'h61); fifo_q.push_back(8'h62);
    got.delete();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (tvalid) got.push_back(tdata);
    end
    check("t5_recover_beats", 32'(got.size()), 32'(2));
    if (got.size() > 0) check("t5_recover_data", 32'(got[0]), 32'(8'h61));

`ifdef FIFO_READER_TLAST_EN
    // Packet framing: len 4, 10 words, then restart after flush.
    drive_edge();
    flush = 1'b1;
    drive_edge();
    flush = 1'b0;
    pkt_len = 16'd4;
    for (int i = 0; i < 10; i++) fifo_q.push_back(8'(8'h71 + i));
    tl_beats.delete();
    rden_n = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (tvalid) begin
        rden_n++;
        if (tlast) tl_beats.push_back(16'(rden_n));
      end
    end
    check("t6_beats", 32'(rden_n), 32'(10));
    check("t6_tlast_count", 32'(tl_beats.size()), 32'(2));
    if (tl_beats.size() == 2) begin
      check("t6_tlast_first", 32'(tl_beats[0]), 32'(4));
      check("t6_tlast_second", 32'(tl_beats[1]), 32'(8));
    end
    drive_edge();
    flush = 1'b1;
    drive_edge();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) fifo_q.push_back(8'(8'h81 + i));
    tl_beats.delete();
    rden_n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (tvalid) begin
        rden_n++;
        if (tlast) tl_beats.push_back(16'(rden_n));
      end
    end
    check("t6_restart_count", 32'(tl_beats.size()), 32'(1));
    if (tl_beats.size() == 1) check("t6_restart_beat", 32'(tl_beats[0]), 32'(4));
`endif

    drive_edge();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
